// File: rtl/ddr_cmd_sched.sv
// DDR command scheduler: arbitrates one read and one write port, sequences the
// ACT/PRE/data/precharge timeline and interleaves periodic auto-refresh.
module ddr_cmd_sched #(
   parameter int REF_INTERVAL = 780,
   parameter int T_RCD        = 2,
   parameter int T_RP         = 3,
   parameter int T_RFC        = 10,
   parameter int BURST_CYC    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic        wr_req,
   input  logic [24:0] wr_addr,
   input  logic        rd_req,
   input  logic [24:0] rd_addr,
   output logic        wr_ack,
   output logic        rd_ack,
   output logic [3:0]  c_state,
   output logic [24:0] sys_addr,
   output logic        busy,
   output logic        ref_overrun
);

   localparam int RW = (REF_INTERVAL < 2) ? 1 : $clog2(REF_INTERVAL + 1);
   localparam logic [RW-1:0] REF_LD = RW'(REF_INTERVAL);
   localparam logic [7:0] RCD_LD   = 8'(T_RCD - 1);
   localparam logic [7:0] RP_LD    = 8'(T_RP - 1);
   localparam logic [7:0] RFC_LD   = 8'(T_RFC - 1);
   localparam logic [7:0] BURST_LD = 8'(BURST_CYC - 1);

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_GRANT = 4'd1;
   localparam logic [3:0] ST_ACT   = 4'd2;
   localparam logic [3:0] ST_TRCD  = 4'd3;
   localparam logic [3:0] ST_PRE   = 4'd4;
   localparam logic [3:0] ST_DATA  = 4'd5;
   localparam logic [3:0] ST_TRP   = 4'd6;
   localparam logic [3:0] ST_AREF  = 4'd7;
   localparam logic [3:0] ST_TRFC  = 4'd8;

   localparam logic [3:0] CMD_IDLE  = 4'b0000;
   localparam logic [3:0] CMD_ACT   = 4'b0001;
   localparam logic [3:0] CMD_RDPRE = 4'b0100;
   localparam logic [3:0] CMD_WRPRE = 4'b0101;
   localparam logic [3:0] CMD_RDDAT = 4'b0110;
   localparam logic [3:0] CMD_WRDAT = 4'b0111;
   localparam logic [3:0] CMD_AREF  = 4'b1101;
   localparam logic [3:0] CMD_TIMER = 4'b1111;

   logic [3:0]    state_q, state_d;
   logic [7:0]    timer_q, timer_d;
   logic          is_wr_q, is_wr_d;
   logic          last_wr_q, last_wr_d;
   logic [24:0]   addr_q, addr_d;
   logic          rd_ack_q, rd_ack_d;
   logic          wr_ack_q, wr_ack_d;
   logic [3:0]    cmd_q, cmd_d;
   logic          busy_q;
   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic          ref_pend_q, ref_pend_d;
   logic          overrun_q, overrun_d;
   logic          pend_clr;

   // Main sequencer; requests and refresh are only considered in IDLE.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      is_wr_d   = is_wr_q;
      last_wr_d = last_wr_q;
      addr_d    = addr_q;
      rd_ack_d  = 1'b0;
      wr_ack_d  = 1'b0;
      pend_clr  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (init_done) begin
               if (ref_pend_q) begin
                  state_d  = ST_AREF;
                  pend_clr = 1'b1;
               end else if (rd_req && (!wr_req || last_wr_q)) begin
                  state_d   = ST_GRANT;
                  is_wr_d   = 1'b0;
                  last_wr_d = 1'b0;
                  addr_d    = rd_addr;
                  rd_ack_d  = 1'b1;
               end else if (wr_req) begin
                  state_d   = ST_GRANT;
                  is_wr_d   = 1'b1;
                  last_wr_d = 1'b1;
                  addr_d    = wr_addr;
                  wr_ack_d  = 1'b1;
               end
            end
         end
         ST_GRANT: state_d = ST_ACT;
         ST_ACT: begin
            state_d = ST_TRCD;
            timer_d = RCD_LD;
         end
         ST_TRCD: begin
            if (timer_q == 8'd0) state_d = ST_PRE;
            else timer_d = timer_q - 8'd1;
         end
         ST_PRE: begin
            state_d = ST_DATA;
            timer_d = BURST_LD;
         end
         ST_DATA: begin
            if (timer_q == 8'd0) begin
               state_d = ST_TRP;
               timer_d = RP_LD;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         ST_TRP: begin
            if (timer_q == 8'd0) state_d = ST_IDLE;
            else timer_d = timer_q - 8'd1;
         end
         ST_AREF: begin
            state_d = ST_TRFC;
            timer_d = RFC_LD;
         end
         ST_TRFC: begin
            if (timer_q == 8'd0) state_d = ST_IDLE;
            else timer_d = timer_q - 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Command code is derived from the next state so it is registered with it.
   always_comb begin
      cmd_d = CMD_IDLE;
      case (state_d)
         ST_ACT:  cmd_d = CMD_ACT;
         ST_TRCD, ST_TRP, ST_TRFC: cmd_d = CMD_TIMER;
         ST_PRE:  cmd_d = is_wr_d ? CMD_WRPRE : CMD_RDPRE;
         ST_DATA: cmd_d = is_wr_d ? CMD_WRDAT : CMD_RDDAT;
         ST_AREF: cmd_d = CMD_AREF;
         default: cmd_d = CMD_IDLE;
      endcase
   end

   // Refresh interval: a pending request that is still unserviced when the
   // next interval expires is an overrun.
   always_comb begin
      ref_cnt_d  = ref_cnt_q;
      ref_pend_d = ref_pend_q & ~pend_clr;
      overrun_d  = overrun_q;
      if (!init_done) begin
         ref_cnt_d = REF_LD;
      end else if (ref_cnt_q <= RW'(1)) begin
         ref_cnt_d  = REF_LD;
         ref_pend_d = 1'b1;
         if (ref_pend_q) overrun_d = 1'b1;
      end else begin
         ref_cnt_d = ref_cnt_q - RW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= 8'd0;
         is_wr_q    <= 1'b0;
         last_wr_q  <= 1'b1;
         addr_q     <= 25'd0;
         rd_ack_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
         cmd_q      <= CMD_IDLE;
         busy_q     <= 1'b0;
         ref_cnt_q  <= REF_LD;
         ref_pend_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         is_wr_q    <= is_wr_d;
         last_wr_q  <= last_wr_d;
         addr_q     <= addr_d;
         rd_ack_q   <= rd_ack_d;
         wr_ack_q   <= wr_ack_d;
         cmd_q      <= cmd_d;
         busy_q     <= (state_d != ST_IDLE);
         ref_cnt_q  <= ref_cnt_d;
         ref_pend_q <= ref_pend_d;
         overrun_q  <= overrun_d;
      end
   end

   assign wr_ack      = wr_ack_q;
   assign rd_ack      = rd_ack_q;
   assign c_state     = cmd_q;
   assign sys_addr    = addr_q;
   assign busy        = busy_q;
   assign ref_overrun = overrun_q;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed bench for ddr_cmd_sched: three instances share stimulus and differ
// only in REF_INTERVAL; each step checks the instance it targets.
module tb_ddr_cmd_sched;

   logic        clk;
   logic        rst;
   logic        init_done;
   logic        wr_req;
   logic [24:0] wr_addr;
   logic        rd_req;
   logic [24:0] rd_addr;

   logic        m_wr_ack, m_rd_ack, m_busy, m_ovr;
   logic [3:0]  m_cs;
   logic [24:0] m_addr;
   logic        t_wr_ack, t_rd_ack, t_busy, t_ovr;
   logic [3:0]  t_cs;
   logic [24:0] t_addr;
   logic        o_wr_ack, o_rd_ack, o_busy, o_ovr;
   logic [3:0]  o_cs;
   logic [24:0] o_addr;

   int checks   = 0;
   int failures = 0;

   ddr_cmd_sched u_main (
      .clk(clk), .rst(rst), .init_done(init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req), .rd_addr(rd_addr),
      .wr_ack(m_wr_ack), .rd_ack(m_rd_ack), .c_state(m_cs),
      .sys_addr(m_addr), .busy(m_busy), .ref_overrun(m_ovr)
   );

   ddr_cmd_sched #(.REF_INTERVAL(20)) u_ref20 (
      .clk(clk), .rst(rst), .init_done(init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req), .rd_addr(rd_addr),
      .wr_ack(t_wr_ack), .rd_ack(t_rd_ack), .c_state(t_cs),
      .sys_addr(t_addr), .busy(t_busy), .ref_overrun(t_ovr)
   );

   ddr_cmd_sched #(.REF_INTERVAL(4)) u_ref4 (
      .clk(clk), .rst(rst), .init_done(init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req), .rd_addr(rd_addr),
      .wr_ack(o_wr_ack), .rd_ack(o_rd_ack), .c_state(o_cs),
      .sys_addr(o_addr), .busy(o_busy), .ref_overrun(o_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Nine cycles after a grant on the main instance: ACT, tRCD, PRE, burst, tRP.
   task automatic check_access(input logic is_wr, input logic [24:0] exp_addr);
      logic [3:0] seq [9];
      logic [3:0] pre;
      logic [3:0] dat;
      pre = is_wr ? 4'b0101 : 4'b0100;
      dat = is_wr ? 4'b0111 : 4'b0110;
      seq = '{4'b0001, 4'b1111, 4'b1111, pre, dat, dat, 4'b1111, 4'b1111, 4'b1111};
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("access_c_state", 32'(m_cs), 32'(seq[i]));
         chk("access_rd_ack", 32'(m_rd_ack), 32'd0);
         chk("access_wr_ack", 32'(m_wr_ack), 32'd0);
         chk("access_busy", 32'(m_busy), 32'd1);
         chk("access_sys_addr", 32'(m_addr), 32'(exp_addr));
      end
   endtask

   initial begin
      rst = 1'b1; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = 25'd0; rd_addr = 25'd0;
      tick();
      tick();

      // Reset values
      chk("rst_c_state", 32'(m_cs), 32'd0);
      chk("rst_sys_addr", 32'(m_addr), 32'd0);
      chk("rst_rd_ack", 32'(m_rd_ack), 32'd0);
      chk("rst_wr_ack", 32'(m_wr_ack), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_overrun", 32'(m_ovr), 32'd0);

      // Init gating: request ignored while init_done is low
      rst = 1'b0; rd_req = 1'b1; rd_addr = 25'h0123456;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("init_c_state", 32'(m_cs), 32'd0);
         chk("init_rd_ack", 32'(m_rd_ack), 32'd0);
         chk("init_busy", 32'(m_busy), 32'd0);
      end

      // Single read
      rst = 1'b1; rd_req = 1'b0;
      tick();
      rst = 1'b0; init_done = 1'b1; rd_req = 1'b1; rd_addr = 25'h1ABCDEF;
      tick();
      chk("rd_grant_ack", 32'(m_rd_ack), 32'd1);
      chk("rd_grant_wr_ack", 32'(m_wr_ack), 32'd0);
      chk("rd_grant_c_state", 32'(m_cs), 32'd0);
      chk("rd_grant_addr", 32'(m_addr), 32'h1ABCDEF);
      chk("rd_grant_busy", 32'(m_busy), 32'd1);
      rd_req = 1'b0;
      check_access(1'b0, 25'h1ABCDEF);
      tick();
      chk("rd_end_c_state", 32'(m_cs), 32'd0);
      chk("rd_end_busy", 32'(m_busy), 32'd0);
      chk("rd_end_addr", 32'(m_addr), 32'h1ABCDEF);
      tick();
      chk("rd_no_regrant", 32'(m_rd_ack), 32'd0);

      // Simultaneous requests held high: rd, wr, rd, wr
      rst = 1'b1;
      tick();
      rst = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
      rd_addr = 25'h0000AAA; wr_addr = 25'h1555000;
      for (int g = 0; g < 4; g++) begin
         logic        exp_wr;
         logic [24:0] exp_a;
         exp_wr = (g % 2 == 1);
         exp_a  = exp_wr ? 25'h1555000 : 25'h0000AAA;
         tick();
         chk("rr_rd_ack", 32'(m_rd_ack), 32'(!exp_wr));
         chk("rr_wr_ack", 32'(m_wr_ack), 32'(exp_wr));
         chk("rr_addr", 32'(m_addr), 32'(exp_a));
         check_access(exp_wr, exp_a);
         tick();
         chk("rr_idle_c_state", 32'(m_cs), 32'd0);
         chk("rr_idle_busy", 32'(m_busy), 32'd0);
      end

      // Reset during WR_DATA
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      tick();
      rst = 1'b0; wr_req = 1'b1; wr_addr = 25'h0155555;
      tick();
      chk("mid_wr_ack", 32'(m_wr_ack), 32'd1);
      wr_req = 1'b0;
      repeat (5) tick();
      chk("mid_in_wr_data", 32'(m_cs), 32'b0111);
      rst = 1'b1;
      tick();
      chk("mid_rst_c_state", 32'(m_cs), 32'd0);
      chk("mid_rst_addr", 32'(m_addr), 32'd0);
      chk("mid_rst_wr_ack", 32'(m_wr_ack), 32'd0);
      chk("mid_rst_rd_ack", 32'(m_rd_ack), 32'd0);
      chk("mid_rst_busy", 32'(m_busy), 32'd0);
      chk("mid_rst_overrun", 32'(m_ovr), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_c_state", 32'(m_cs), 32'd0);
         chk("post_rst_wr_ack", 32'(m_wr_ack), 32'd0);
         chk("post_rst_busy", 32'(m_busy), 32'd0);
      end

      // Refresh tie on the REF_INTERVAL=20 instance: refresh wins over wr
      rst = 1'b1;
      tick();
      rst = 1'b0; wr_addr = 25'h0AAAAAA;
      repeat (20) tick();
      chk("tie_pre_c_state", 32'(t_cs), 32'd0);
      wr_req = 1'b1;
      tick();
      chk("tie_aref", 32'(t_cs), 32'b1101);
      chk("tie_aref_wr_ack", 32'(t_wr_ack), 32'd0);
      chk("tie_aref_busy", 32'(t_busy), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("tie_trfc", 32'(t_cs), 32'b1111);
         chk("tie_trfc_wr_ack", 32'(t_wr_ack), 32'd0);
      end
      tick();
      chk("tie_idle", 32'(t_cs), 32'd0);
      chk("tie_idle_wr_ack", 32'(t_wr_ack), 32'd0);
      tick();
      chk("tie_wr_grant", 32'(t_wr_ack), 32'd1);
      chk("tie_wr_addr", 32'(t_addr), 32'h0AAAAAA);
      wr_req = 1'b0;

      // Overrun on the REF_INTERVAL=4 instance under continuous traffic
      rst = 1'b1;
      tick();
      rst = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
      tick();
      chk("ovr_early", 32'(o_ovr), 32'd0);
      repeat (40) tick();
      chk("ovr_set", 32'(o_ovr), 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("ovr_sticky", 32'(o_ovr), 32'd1);
      end
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      tick();
      chk("ovr_cleared", 32'(o_ovr), 32'd0);
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
